led_sequence_monitor: RTL and testbench
=======================================

Name: led_sequence_monitor

Overview:
- Receive-side checker for the bouncing one-hot LED sequence: L0→L1→…→L(N-1)→…→L1→L0→L1…
- Samples the LED bus on a valid strobe and decodes it to position and direction.
- Locks onto a legal sequence, flags every deviation and counts errors.
- Sits next to the LED sequencer in self-checking demo and test builds; its outputs drive status LEDs and the bench scoreboard.

Parameters:
- N, 4, number of LEDs; legal range N ≥ 2.
- ERR_W, 8, width of the saturating error counter.
- POS_W, $clog2(N), width of the position index; derived, not overridden.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- reset, input, 1, synchronous, active-low.
- led_in, input, N, observed LED pattern; bit i is LED i.
- led_valid, input, 1, led_in is sampled only in cycles where this is 1.
- pos, output, POS_W, index of the last legal one-hot sample.
- dir, output, 1, 0 = index increasing (shift left), 1 = index decreasing.
- locked, output, 1, monitor is tracking a verified sequence.
- err_pulse, output, 1, one-cycle pulse on each detected deviation while locked.
- err_count, output, ERR_W, saturating count of err_pulse events.
- period_done, output, 1, one-cycle pulse when a locked sample returns to index 0.

Behaviour:
- Reset is decided as: reset reset, synchronous, active-low; clock clk. While reset=0 at a clk edge:
  - pos=0, dir=0, locked=0, err_pulse=0, err_count=0, period_done=0, state=HUNT.
  - Asserting reset mid-operation discards all tracking state in the same edge.
- Sampling:
  - Cycles with led_valid=0 change no state.
  - err_pulse and period_done are forced to 0 in those cycles.
  - All outputs are registered and update on the edge that samples led_in (latency 1).
- Legal sample: exactly one bit set. idx = index of that bit.
- States:
  - HUNT:
    - Legal sample → pos=idx, go to SYNC.
    - Illegal sample → stay in HUNT. No error is counted.
  - SYNC:
    - Legal sample with |idx−pos|=1 → dir = (idx>pos)?0:1, pos=idx, locked=1, go to LOCK.
    - Legal but not adjacent (including equal) → pos=idx, stay in SYNC.
    - Illegal sample → go to HUNT. No error is counted.
  - LOCK, expected index:
    - dir=0 and pos<N-1 → exp=pos+1, dir unchanged.
    - dir=0 and pos=N-1 → exp=N-2, dir becomes 1 (bounce).
    - dir=1 and pos>0 → exp=pos-1, dir unchanged.
    - dir=1 and pos=0 → exp=1, dir becomes 0 (bounce).
    - Endpoints appear exactly once per pass; a repeated endpoint is a mismatch.
  - LOCK, sample equal to exp:
    - pos=exp and dir is updated per the rules above.
    - period_done=1 if exp=0.
  - LOCK, mismatch or illegal sample:
    - err_pulse=1; err_count += 1, saturating at 2^ERR_W−1; locked=0.
    - If the sample is legal → pos=idx, go to SYNC. If illegal → go to HUNT.
- N=2: the sequence alternates 0,1,0,1. Bounce rules apply at both ends every sample.

Optional Feature:
- Macro LEDSEQ_REPEAT_EN.
- Defined:
  - In LOCK, a legal sample with idx equal to the current pos is a stall.
  - On a stall, pos, dir and counters are unchanged; no error and no period_done are produced.
- Undefined:
  - A repeated sample is a mismatch and is handled per the LOCK rules (err_pulse, go to SYNC).

Test Plan:
- N=4, reset=0 for 2 cycles, then valid samples 0001,0010,0100,1000,0100,0010,0001,0010:
  - locked=1 after the second sample.
  - dir goes 0→1 after 1000 and 1→0 after 0001.
  - period_done pulses once, on 0001.
  - err_count stays 0.
- Locked, dir=0, pos=1, then sample 1000 → err_pulse=1, err_count=1, locked=0, state SYNC, pos=3.
- Locked, then sample 0110 → err_pulse=1, state HUNT, pos unchanged. Following 0001,0010 → relocked with dir=0.
- Locked at pos=3, then sample 1000 again:
  - Macro undefined → error, err_count incremented.
  - Macro defined → no error, pos=3, locked stays 1.
- ERR_W=2, force 5 consecutive locked mismatches → err_count stops at 3.
- Locked mid-sequence with led_valid toggling 1,0,1: outputs hold during the 0 cycles. Then reset=0 for one edge → every output is at its reset value on the next cycle.

Source files
------------

// File: rtl/led_sequence_monitor.sv
// led_sequence_monitor
//
// Receive-side checker for a bouncing one-hot LED sequence
// (L0, L1, ..., L(N-1), ..., L1, L0, L1, ...). Each valid sample of the LED
// bus is decoded to an index. The monitor locks onto a legal sequence,
// flags every deviation while locked, and keeps a saturating error count.
//
// Parameters:
//   N      number of LEDs (N >= 2)
//   ERR_W  width of the saturating error counter
//   POS_W  width of the position index, derived as $clog2(N)
//
// Ports:
//   clk          clock, all logic on the rising edge
//   reset        synchronous, active-low reset
//   led_in       observed LED pattern, bit i is LED i
//   led_valid    led_in is sampled only in cycles where this is 1
//   pos          index of the last legal one-hot sample
//   dir          0 = index increasing, 1 = index decreasing
//   locked       monitor is tracking a verified sequence
//   err_pulse    one-cycle pulse on each deviation seen while locked
//   err_count    saturating count of err_pulse events
//   period_done  one-cycle pulse when a locked sample returns to index 0
//
// Optional feature (macro LEDSEQ_REPEAT_EN):
//   When defined, a locked sample that repeats the current position is
//   treated as a stall: nothing changes and no error is reported. When
//   undefined, a repeated sample is an ordinary mismatch.

module led_sequence_monitor #(
  parameter  int N     = 4,
  parameter  int ERR_W = 8,
  localparam int POS_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     led_in,
  input  logic             led_valid,
  output logic [POS_W-1:0] pos,
  output logic             dir,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             period_done
);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [POS_W-1:0] POS_ONE  = 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N - 1);
  localparam logic [POS_W:0]   WIDE_ONE = 1;
  localparam logic [ERR_W-1:0] ERR_ONE  = 1;
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             err_pulse_q, err_pulse_d;
  logic             period_done_q, period_done_d;

  logic             legal;
  logic [POS_W-1:0] idx;
  logic             adjacent;
  logic [POS_W-1:0] exp_pos;
  logic             exp_dir;
  logic             stall;

  // Sample decode: a legal sample has exactly one bit set. idx is only
  // meaningful when legal is true.
  always_comb begin
    legal = (led_in != '0) && ((led_in & (led_in - N'(1))) == '0);
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (led_in[i]) begin
        idx = POS_W'(i);
      end
    end
  end

  // Adjacency is compared one bit wider so that pos+1 cannot wrap back to
  // zero when N is a power of two.
  always_comb begin
    adjacent = ({1'b0, idx} == ({1'b0, pos_q} + WIDE_ONE)) ||
               ({1'b0, pos_q} == ({1'b0, idx} + WIDE_ONE));
  end

  // Expected next index while locked. dir records the direction of the step
  // just taken, so it flips on the first step away from an endpoint, and an
  // endpoint can never be expected twice in a row.
  always_comb begin
    exp_pos = pos_q;
    exp_dir = dir_q;
    if (!dir_q) begin
      if (pos_q != POS_LAST) begin
        exp_pos = pos_q + POS_ONE;
        exp_dir = 1'b0;
      end else begin
        exp_pos = POS_LAST - POS_ONE;
        exp_dir = 1'b1;
      end
    end else begin
      if (pos_q != '0) begin
        exp_pos = pos_q - POS_ONE;
        exp_dir = 1'b1;
      end else begin
        exp_pos = POS_ONE;
        exp_dir = 1'b0;
      end
    end
  end

`ifdef LEDSEQ_REPEAT_EN
  // A repeat of the current position is tolerated as a stall.
  always_comb begin
    stall = legal && (idx == pos_q);
  end
`else
  always_comb begin
    stall = 1'b0;
  end
`endif

  // State register: holds the FSM state and every registered output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= HUNT;
      pos_q         <= '0;
      dir_q         <= 1'b0;
      err_count_q   <= '0;
      err_pulse_q   <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      dir_q         <= dir_d;
      err_count_q   <= err_count_d;
      err_pulse_q   <= err_pulse_d;
      period_done_q <= period_done_d;
    end
  end

  // Next-state logic. Pulses default to 0, so cycles without led_valid
  // both hold all tracking state and clear the pulses.
  always_comb begin
    state_d       = state_q;
    pos_d         = pos_q;
    dir_d         = dir_q;
    err_count_d   = err_count_q;
    err_pulse_d   = 1'b0;
    period_done_d = 1'b0;

    if (led_valid) begin
      case (state_q)
        HUNT: begin
          if (legal) begin
            pos_d   = idx;
            state_d = SYNC;
          end
        end

        SYNC: begin
          if (!legal) begin
            state_d = HUNT;
          end else begin
            pos_d = idx;
            if (adjacent) begin
              dir_d   = (idx < pos_q);
              state_d = LOCK;
            end
          end
        end

        LOCK: begin
          if (legal && (idx == exp_pos)) begin
            pos_d         = exp_pos;
            dir_d         = exp_dir;
            period_done_d = (exp_pos == '0);
          end else if (!stall) begin
            err_pulse_d = 1'b1;
            if (err_count_q != ERR_MAX) begin
              err_count_d = err_count_q + ERR_ONE;
            end
            if (legal) begin
              pos_d   = idx;
              state_d = SYNC;
            end else begin
              state_d = HUNT;
            end
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  // Output logic: everything comes straight from registers; locked is a
  // decode of the registered state.
  always_comb begin
    pos         = pos_q;
    dir         = dir_q;
    locked      = (state_q == LOCK);
    err_pulse   = err_pulse_q;
    err_count   = err_count_q;
    period_done = period_done_q;
  end

endmodule

// File: tb/tb_led_sequence_monitor.sv
// tb_led_sequence_monitor
//
// Bench for led_sequence_monitor with N=4. A main instance (ERR_W=8) and a
// second instance (ERR_W=2) share the same stimulus so that counter
// saturation can be checked at both widths. Directed vectors come from a
// table, followed by randomized traffic checked against a phase-based
// model of the bouncing sequence, and a long error run that saturates the
// 8-bit counter.

module tb_led_sequence_monitor;

  localparam int NL = 4;
  localparam int P  = 2 * (NL - 1);

`ifdef LEDSEQ_REPEAT_EN
  localparam int REP_ERR = 0;
  localparam int REP_LCK = 1;
`else
  localparam int REP_ERR = 1;
  localparam int REP_LCK = 0;
`endif

  logic          clk;
  logic          reset;
  logic [NL-1:0] led_in;
  logic          led_valid;

  logic [1:0] pos;
  logic       dir;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;
  logic       period_done;

  logic [1:0] sat_pos;
  logic       sat_dir;
  logic       sat_locked;
  logic       sat_err_pulse;
  logic [1:0] sat_err_count;
  logic       sat_period_done;

  int total = 0;
  int bad   = 0;

  // Behavioural model: mode 0=hunting, 1=syncing, 2=locked. While locked the
  // position is a function of a phase 0..P-1 around the bounce cycle.
  int m_mode, m_pos, m_dir, m_phase, m_errs, m_err, m_pd;

  typedef struct {
    logic          rst_n;
    logic          valid;
    logic [NL-1:0] led;
    int            e_pos;
    int            e_dir;
    int            e_lck;
    int            e_err;
    int            e_cnt;
    int            e_pd;
  } vec_t;

  vec_t vecs[$];

  led_sequence_monitor #(.N(NL), .ERR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .led_in     (led_in),
    .led_valid  (led_valid),
    .pos        (pos),
    .dir        (dir),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .period_done(period_done)
  );

  led_sequence_monitor #(.N(NL), .ERR_W(2)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .led_in     (led_in),
    .led_valid  (led_valid),
    .pos        (sat_pos),
    .dir        (sat_dir),
    .locked     (sat_locked),
    .err_pulse  (sat_err_pulse),
    .err_count  (sat_err_count),
    .period_done(sat_period_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pos_of(int ph);
    return (ph < NL) ? ph : (P - ph);
  endfunction

  function automatic int dir_of(int ph);
    return (ph >= 1 && ph <= NL - 1) ? 0 : 1;
  endfunction

  function automatic int idx_of(logic [NL-1:0] v);
    int r = 0;
    for (int i = 0; i < NL; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic vec_t mk(logic r, logic v, logic [NL-1:0] l,
                              int p, int d, int lk, int e, int c, int pd);
    vec_t t;
    t.rst_n = r; t.valid = v; t.led = l;
    t.e_pos = p; t.e_dir = d; t.e_lck = lk;
    t.e_err = e; t.e_cnt = c; t.e_pd = pd;
    return t;
  endfunction

  task automatic model_update(input logic rst_n, input logic valid,
                              input logic [NL-1:0] led);
    int  idx;
    int  nxt;
    bit  legal;
    m_err = 0;
    m_pd  = 0;
    if (!rst_n) begin
      m_mode = 0; m_pos = 0; m_dir = 0; m_phase = 0; m_errs = 0;
    end else if (valid) begin
      legal = ($countones(led) == 1);
      idx   = idx_of(led);
      case (m_mode)
        0: if (legal) begin m_pos = idx; m_mode = 1; end
        1: begin
          if (!legal) m_mode = 0;
          else if (idx - m_pos == 1 || m_pos - idx == 1) begin
            m_dir   = (idx > m_pos) ? 0 : 1;
            m_pos   = idx;
            m_mode  = 2;
            m_phase = (m_dir == 0) ? idx : (P - idx) % P;
          end else m_pos = idx;
        end
        default: begin
          nxt = (m_phase + 1) % P;
          if (legal && idx == pos_of(nxt)) begin
            m_phase = nxt;
            m_pos   = idx;
            m_dir   = dir_of(nxt);
            m_pd    = (nxt == 0) ? 1 : 0;
          end else if (REP_LCK == 1 && legal && idx == m_pos) begin
            m_pd = 0;
          end else begin
            m_err  = 1;
            m_errs = m_errs + 1;
            if (legal) begin m_pos = idx; m_mode = 1; end
            else m_mode = 0;
          end
        end
      endcase
    end
  endtask

  task automatic check_one(input string name, input string what,
                           input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s.%s: got %0d want %0d", name, what, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input int e_pos, input int e_dir,
                             input int e_lck, input int e_err, input int e_cnt,
                             input int e_pd);
    check_one(name, "pos",         int'(pos),           e_pos);
    check_one(name, "dir",         int'(dir),           e_dir);
    check_one(name, "locked",      int'(locked),        e_lck);
    check_one(name, "err_pulse",   int'(err_pulse),     e_err);
    check_one(name, "err_count",   int'(err_count),     sat(e_cnt, 255));
    check_one(name, "period_done", int'(period_done),   e_pd);
    check_one(name, "sat_pos",     int'(sat_pos),       e_pos);
    check_one(name, "sat_locked",  int'(sat_locked),    e_lck);
    check_one(name, "sat_err",     int'(sat_err_pulse), e_err);
    check_one(name, "sat_count",   int'(sat_err_count), sat(e_cnt, 3));
    check_one(name, "sat_dir",     int'(sat_dir),       e_dir);
    check_one(name, "sat_pd",      int'(sat_period_done), e_pd);
  endtask

  task automatic applyStimulus(input logic rst_n, input logic valid,
                               input logic [NL-1:0] led);
    reset     = rst_n;
    led_valid = valid;
    led_in    = led;
    @(posedge clk);
    #1;
    model_update(rst_n, valid, led);
  endtask

  task automatic check_model(input string name);
    checkOutput(name, m_pos, m_dir, (m_mode == 2) ? 1 : 0, m_err, m_errs, m_pd);
  endtask

  initial begin
    logic [NL-1:0] l;
    logic          v;
    logic          r;
    int            k;

    reset = 1'b0; led_valid = 1'b0; led_in = '0;
    m_mode = 0; m_pos = 0; m_dir = 0; m_phase = 0; m_errs = 0; m_err = 0; m_pd = 0;

    //                 rst  vld  led      pos dir lck err cnt pd
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1'b0, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1'b1, 1'b1, 4'b0001, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1'b1, 1'b1, 4'b0010, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1'b1, 1'b1, 4'b0100, 2, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1000, 3, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1'b1, 1'b1, 4'b0100, 2, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1'b1, 1'b1, 4'b0010, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1'b1, 1'b1, 4'b0001, 0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1'b1, 1'b1, 4'b0010, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1000, 3, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1'b1, 1'b1, 4'b0100, 2, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1'b1, 1'b1, 4'b0110, 2, 1, 0, 1, 2, 0));
    vecs.push_back(mk(1'b1, 1'b1, 4'b0001, 0, 1, 0, 0, 2, 0));
    vecs.push_back(mk(1'b1, 1'b1, 4'b0010, 1, 0, 1, 0, 2, 0));
    vecs.push_back(mk(1'b1, 1'b1, 4'b0100, 2, 0, 1, 0, 2, 0));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1000, 3, 0, 1, 0, 2, 0));
    vecs.push_back(mk(1'b1, 1'b1, 4'b1000, 3, 0, REP_LCK, REP_ERR, 2 + REP_ERR, 0));
    vecs.push_back(mk(1'b1, 1'b1, 4'b0100, 2, 1, 1, 0, 2 + REP_ERR, 0));
    vecs.push_back(mk(1'b1, 1'b0, 4'b1111, 2, 1, 1, 0, 2 + REP_ERR, 0));
    vecs.push_back(mk(1'b1, 1'b1, 4'b0010, 1, 1, 1, 0, 2 + REP_ERR, 0));
    vecs.push_back(mk(1'b1, 1'b0, 4'b0001, 1, 1, 1, 0, 2 + REP_ERR, 0));
    vecs.push_back(mk(1'b1, 1'b0, 4'b1000, 1, 1, 1, 0, 2 + REP_ERR, 0));
    vecs.push_back(mk(1'b1, 1'b1, 4'b0001, 0, 1, 1, 0, 2 + REP_ERR, 1));
    vecs.push_back(mk(1'b1, 1'b0, 4'b0001, 0, 1, 1, 0, 2 + REP_ERR, 0));
    vecs.push_back(mk(1'b0, 1'b1, 4'b0010, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1'b1, 1'b1, 4'b0010, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1'b1, 1'b1, 4'b0001, 0, 1, 1, 0, 0, 0));
    // Illegal sample while locked: error pulse, then it clears with valid low.
    vecs.push_back(mk(1'b1, 1'b1, 4'b0000, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(1'b1, 1'b0, 4'b0000, 0, 1, 0, 0, 1, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst_n, vecs[i].valid, vecs[i].led);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_pos, vecs[i].e_dir,
                  vecs[i].e_lck, vecs[i].e_err, vecs[i].e_cnt, vecs[i].e_pd);
    end

    // Randomized traffic, mostly following the legal sequence.
    applyStimulus(1'b0, 1'b0, '0);
    check_model("rnd_reset");
    for (int n = 0; n < 2000; n++) begin
      k = int'($urandom_range(0, 99));
      r = 1'b1;
      v = 1'b1;
      if (m_mode == 2)
        l = NL'(1) << pos_of((m_phase + 1) % P);
      else if (m_pos < NL - 1)
        l = NL'(1) << (m_pos + 1);
      else
        l = NL'(1) << (m_pos - 1);
      if (k < 2) r = 1'b0;
      else if (k < 12) begin v = 1'b0; l = NL'($urandom); end
      else if (k < 20) l = NL'($urandom);
      else if (k < 30) l = NL'(1) << $urandom_range(0, NL - 1);
      applyStimulus(r, v, l);
      check_model($sformatf("rnd%0d", n));
    end

    // Long mismatch run to saturate the 8-bit counter.
    applyStimulus(1'b0, 1'b0, '0);
    check_model("sat_reset");
    applyStimulus(1'b1, 1'b1, 4'b0001);
    applyStimulus(1'b1, 1'b1, 4'b0010);
    check_model("sat_lock");
    for (int n = 0; n < 300; n++) begin
      applyStimulus(1'b1, 1'b1, 4'b0001);
      check_model($sformatf("sat_err%0d", n));
      applyStimulus(1'b1, 1'b1, 4'b0010);
      check_model($sformatf("sat_relock%0d", n));
    end
    check_one("sat_final", "err_count8", int'(err_count), 255);
    check_one("sat_final", "err_count2", int'(sat_err_count), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
